fp16_seq_multiplier: RTL and testbench

- Multi-cycle IEEE-754 half-precision multiplier; the inverse operation to the team's FP16 divider, sharing its field layout and conventions.
- Shift-add mantissa datapath, one partial product per cycle, start/done handshake.
- Feeds FP datapath tests alongside the divider so that a*b/b round-trips can be checked.

---
 rtl/fp16_seq_multiplier_if.sv | 27 ++
 rtl/fp16_seq_multiplier.sv | 172 +++++++++++++++++
 tb/tb_fp16_seq_multiplier.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fp16_seq_multiplier_if.sv
// rtl/fp16_seq_multiplier_if.sv - request/result bundle for the FP16 sequential multiplier
interface fp16_seq_multiplier_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output start, a, b,
    input  result, busy, done, overflow, underflow, invalid
  );

  modport slave (
    input  start, a, b,
    output result, busy, done, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp16_seq_multiplier.sv
// rtl/fp16_seq_multiplier.sv - multi-cycle half-precision multiplier, shift-add significand datapath
module fp16_seq_multiplier #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fp16_seq_multiplier_if.slave   bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XW     = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SIG_W - 1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0]        QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, SPEC} state_t;

  state_t                 state_q, state_d;
  logic [W-2:0]           op_a_q, op_b_q;
  logic                   sign_q;
  logic [PROD_W-1:0]      mcand_q;
  logic [PROD_W-1:0]      prod_q;
  logic [SIG_W-1:0]       mplier_q;
  logic [CNT_W-1:0]       cnt_q;
  logic signed [XW-1:0]   exp_q;
  logic [W-1:0]           result_q;
  logic                   busy_q, done_q, ovf_q, unf_q, inv_q;

  // Field views exclude the sign bit; subnormals fall into the zero class.
  function automatic logic is_zero(input logic [W-2:0] v);
    return v[W-2 -: EXP_W] == '0;
  endfunction

  function automatic logic is_inf(input logic [W-2:0] v);
    return (v[W-2 -: EXP_W] == '1) && (v[MAN_W-1:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [W-2:0] v);
    return (v[W-2 -: EXP_W] == '1) && (v[MAN_W-1:0] != '0);
  endfunction

  logic in_special;
  assign in_special = is_zero(bus.a[W-2:0]) || is_zero(bus.b[W-2:0]) ||
                      (&bus.a[W-2 -: EXP_W]) || (&bus.b[W-2 -: EXP_W]);

  logic [W-1:0] spec_result;
  logic         spec_invalid;
  always_comb begin
    spec_invalid = is_nan(op_a_q) || is_nan(op_b_q) ||
                   (is_inf(op_a_q) && is_zero(op_b_q)) ||
                   (is_inf(op_b_q) && is_zero(op_a_q));
    if (spec_invalid)
      spec_result = QNAN;
    else if (is_inf(op_a_q) || is_inf(op_b_q))
      spec_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_result = {sign_q, {(W-1){1'b0}}};
  end

  // Product of two [1,2) significands lies in [1,4): top bit set means one extra exponent step.
  logic signed [XW-1:0] norm_exp;
  logic [MAN_W-1:0]     norm_man;
  logic                 norm_ovf, norm_unf;
  always_comb begin
    if (prod_q[PROD_W-1]) begin
      norm_exp = exp_q + XW'(1);
      norm_man = prod_q[PROD_W-2 -: MAN_W];
    end else begin
      norm_exp = exp_q;
      norm_man = prod_q[PROD_W-3 -: MAN_W];
    end
    norm_ovf = norm_exp >= EXP_MAX;
    norm_unf = norm_exp <= EXP_ZERO;
  end

  logic unused_prod_bits;
  assign unused_prod_bits = ^prod_q[MAN_W-2:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = in_special ? SPEC : MUL;
      MUL:     if (cnt_q == CNT_LAST) state_d = NORM;
      NORM:    state_d = IDLE;
      SPEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_a_q   <= bus.a[W-2:0];
            op_b_q   <= bus.b[W-2:0];
            sign_q   <= bus.a[W-1] ^ bus.b[W-1];
            mcand_q  <= {{(PROD_W-SIG_W){1'b0}}, 1'b1, bus.a[MAN_W-1:0]};
            mplier_q <= {1'b1, bus.b[MAN_W-1:0]};
            prod_q   <= '0;
            cnt_q    <= '0;
            exp_q    <= XW'(bus.a[W-2 -: EXP_W]) + XW'(bus.b[W-2 -: EXP_W]) - XW'(BIAS);
            busy_q   <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
          end
        end
        MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        NORM: begin
          if (norm_ovf) begin
            result_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_q    <= 1'b1;
          end else if (norm_unf) begin
            result_q <= {sign_q, {(W-1){1'b0}}};
            unf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, norm_exp[EXP_W-1:0], norm_man};
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        SPEC: begin
          result_q <= spec_result;
          inv_q    <= spec_invalid;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.invalid   = inv_q;
endmodule

// File: tb/tb_fp16_seq_multiplier.sv
// tb/tb_fp16_seq_multiplier.sv - directed bench with value-level FP16 product model and scoreboard
module tb_fp16_seq_multiplier;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  fp16_seq_multiplier_if bus();

  fp16_seq_multiplier dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          acc;
  } op_t;
  op_t pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Value-level model: multiply integer significands, locate the leading one, truncate to 10 bits.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic [2:0] f, output int lat);
    int  ex, ey, mx, my, msb, e, m;
    bit  zx, zy, ix, iy, nx, ny, s;
    longint p;
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    mx = int'(x[9:0]);   my = int'(y[9:0]);
    s  = x[15] ^ y[15];
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 31) && (mx == 0); iy = (ey == 31) && (my == 0);
    nx = (ex == 31) && (mx != 0); ny = (ey == 31) && (my != 0);
    f = 3'b000;
    lat = 1;
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      r = 16'h7E00; f = 3'b001;
    end else if (ix || iy) begin
      r = s ? 16'hFC00 : 16'h7C00;
    end else if (zx || zy) begin
      r = s ? 16'h8000 : 16'h0000;
    end else begin
      lat = 12;
      p = longint'(1024 + mx) * longint'(1024 + my);
      msb = 0;
      for (int i = 0; i < 24; i++) if (p[i]) msb = i;
      e = ex + ey - 15 + (msb - 20);
      m = int'((p >> (msb - 10)) & 64'd1023);
      if (e >= 31) begin
        r = s ? 16'hFC00 : 16'h7C00; f = 3'b100;
      end else if (e <= 0) begin
        r = s ? 16'h8000 : 16'h0000; f = 3'b010;
      end else begin
        r = 16'((s ? 32768 : 0) + e * 1024 + m);
      end
    end
  endfunction

  // Scoreboard: every cycle out of reset, busy must track outstanding work and done must match the model.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.done) begin
        if (pend.size() == 0) begin
          chk("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          op_t         e;
          logic [15:0] r;
          logic [2:0]  f;
          int          lat;
          e = pend.pop_front();
          model(e.a, e.b, r, f, lat);
          chk("model_result", 32'(bus.result), 32'(r));
          chk("model_flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'(f));
          chk("latency", 32'(cyc - e.acc), 32'(lat));
          chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end else begin
        chk("busy_track", 32'(bus.busy), 32'(pend.size() != 0));
      end
    end
  end

  // Call at a negedge with the DUT idle; returns just after the accepting edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    op_t o;
    bus.a = x; bus.b = y; bus.start = 1'b1;
    @(posedge clk);
    #1;
    o.a = x; o.b = y; o.acc = cyc;
    pend.push_back(o);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] er, input logic [2:0] ef);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      chk("done_timeout", 32'(seen), 32'd1);
    end else begin
      chk("lit_result", 32'(bus.result), 32'(er));
      chk("lit_flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'(ef));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'd0);
  endtask

  logic [15:0] va [12];
  logic [15:0] vb [12];
  logic [15:0] vr [12];
  logic [2:0]  vf [12];

  initial begin
    va[0]  = 16'h3E00; vb[0]  = 16'h4000; vr[0]  = 16'h4200; vf[0]  = 3'b000;
    va[1]  = 16'h3E00; vb[1]  = 16'h3E00; vr[1]  = 16'h4080; vf[1]  = 3'b000;
    va[2]  = 16'hBC00; vb[2]  = 16'h3C00; vr[2]  = 16'hBC00; vf[2]  = 3'b000;
    va[3]  = 16'h7BFF; vb[3]  = 16'h7BFF; vr[3]  = 16'h7C00; vf[3]  = 3'b100;
    va[4]  = 16'h0400; vb[4]  = 16'h0400; vr[4]  = 16'h0000; vf[4]  = 3'b010;
    va[5]  = 16'h7C00; vb[5]  = 16'h0000; vr[5]  = 16'h7E00; vf[5]  = 3'b001;
    va[6]  = 16'h4000; vb[6]  = 16'h4000; vr[6]  = 16'h4400; vf[6]  = 3'b000;
    va[7]  = 16'h3555; vb[7]  = 16'h3C00; vr[7]  = 16'h3555; vf[7]  = 3'b000;
    va[8]  = 16'h7E00; vb[8]  = 16'h3C00; vr[8]  = 16'h7E00; vf[8]  = 3'b001;
    va[9]  = 16'hFC00; vb[9]  = 16'h4000; vr[9]  = 16'hFC00; vf[9]  = 3'b000;
    va[10] = 16'h8000; vb[10] = 16'h4000; vr[10] = 16'h8000; vf[10] = 3'b000;
    va[11] = 16'h0001; vb[11] = 16'h3C00; vr[11] = 16'h0000; vf[11] = 3'b000;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Each issue follows wait_done in the same done cycle, so every op after the first is back-to-back.
    for (int i = 0; i < 12; i++) begin
      issue(va[i], vb[i]);
      wait_done(vr[i], vf[i]);
    end

    // A start pulse during busy must not disturb the operation in flight.
    issue(16'h3E00, 16'h4000);
    repeat (3) @(negedge clk);
    bus.a = 16'h4400; bus.b = 16'h4400; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(16'h4200, 3'b000);
    repeat (14) @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    issue(16'h3E00, 16'h3E00);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    pend.delete();
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (14) @(negedge clk);
    issue(16'hBC00, 16'h4000);
    wait_done(16'hC000, 3'b000);

    repeat (3) @(negedge clk);
    chk("result_held", 32'(bus.result), 32'h0000C000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
